ct_ct_mult_pipe: RTL
====================

CT_CT_MULT_PIPE -- requirements
Module: ct_ct_mult_pipe

Interface
REQ-001 SHALL have parameter W, 32, coefficient width in bits.
REQ-002 SHALL have parameter Q, 32'hFFF00001, modulus; Q < 2^W.
REQ-003 SHALL have parameter N, 1024, coefficients per ciphertext polynomial.
REQ-004 SHALL have parameter LANES, 4, coefficients per beat; N divisible by LANES; NB = N/LANES beats.
REQ-005 SHALL have parameter LOG_BASE, 8, log2 of gadget base.
REQ-006 SHALL have parameter NUM_DIGITS, 4, decomposition digits; NUM_DIGITS*LOG_BASE >= W.
REQ-007 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-008 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-009 SHALL have ports a1, b1, a2, b2, input, LANES*W each, lane-packed coefficients of ct1.A, ct1.B, ct2.A, ct2.B; lane 0 in LSBs.
REQ-010 SHALL have ports in_valid (input, 1) and in_ready (output, 1), input handshake.
REQ-011 SHALL have ports d0, d1, d2, output, LANES*W each, reduced products per lane.
REQ-012 SHALL have port d2_digits, output, LANES*NUM_DIGITS*LOG_BASE, lane-major digits, digit 0 in LSBs of each lane.
REQ-013 SHALL have ports out_valid (output, 1) and out_ready (input, 1), output handshake.
REQ-014 SHALL have ports out_idx (output, clog2(NB)), out_last (output, 1), done (output, 1), busy (output, 1).

Function
REQ-015 Per lane: d0 = b1*b2 mod Q; d1 = a1*a2 mod Q; d2 = ((a1*b2 mod Q) + (b1*a2 mod Q)) mod Q; products full 2W bits, sum W+1 bits.
REQ-016 Digit i of lane = floor(d2 / 2^(i*LOG_BASE)) mod 2^LOG_BASE.
REQ-017 Beat accepted when in_valid && in_ready; delivered when out_valid && out_ready.
REQ-018 Three-stage pipeline: S1 products, S2 per-product reduction and D2 add, S3 final D2 reduction and decomposition; accepted beat appears on outputs exactly 3 cycles later absent stalls.
REQ-019 Global stall: when out_valid && !out_ready, all stages hold and outputs stay stable; in_ready deasserted.
REQ-020 Bubbles propagate as invalid stages; not collapsed.
REQ-021 FSM states IDLE, ACCEPT, DRAIN.
REQ-022 IDLE -> ACCEPT on first accepted beat; ACCEPT -> DRAIN on acceptance of beat NB-1; DRAIN -> IDLE on delivery of beat with out_last.
REQ-023 in_ready = 0 in DRAIN; next ciphertext accepted only after return to IDLE.
REQ-024 Input beat counter increments per accepted beat, wraps to 0 after NB-1; travels with beat to form out_idx; out_last = (out_idx == NB-1).
REQ-025 done pulses high for exactly one cycle, the cycle after out_last delivery; busy = (state != IDLE).
REQ-026 NB = 1 SHALL go IDLE -> DRAIN directly.

Reset
REQ-027 rst asserted at any time, including mid-ciphertext, SHALL clear state to IDLE, counters to 0, all stage valids to 0; in-flight beats discarded.
REQ-028 Reset values: out_valid 0, d0/d1/d2/d2_digits 0, out_idx 0, out_last 0, done 0, busy 0; in_ready 1 after reset.

Configuration
REQ-029 Macro CT_MULT_DECOMP_EN: defined SHALL implement REQ-016 decomposition in S3.
REQ-030 Undefined: d2_digits SHALL be constant 0, no decomposition logic; all other behaviour and latency unchanged.

Verification
REQ-031 Lane 0 a1=b1=a2=b2=Q-1 -> d0=1, d1=1, d2=2; with CT_MULT_DECOMP_EN digits 02,00,00,00.
REQ-032 Lane 0 a1=3,b1=5,a2=7,b2=11 -> d0=55, d1=21, d2=68 at cycle accept+3; digit0=0x44.
REQ-033 NB back-to-back beats, out_ready=1 -> out_idx 0..NB-1, out_last only at NB-1, done 1 cycle later, in_ready low in DRAIN.
REQ-034 out_ready low 5 cycles mid-stream -> outputs frozen, in_ready low, no beat lost or duplicated vs scoreboard.
REQ-035 rst pulse after 10 beats accepted -> out_valid 0 next cycle, busy 0; new ciphertext starts out_idx 0.
REQ-036 Macro undefined, random inputs -> d2_digits always 0, d0/d1/d2 match model.

Source files
------------

// File: rtl/ct_ct_mult_pipe.sv
// ct_ct_mult_pipe: lane-parallel ciphertext x ciphertext tensor product
// modulo Q. Three pipeline stages: S1 raw 2W-bit products, S2 per-product
// reduction plus the D2 cross-term add, S3 final D2 reduction and optional
// gadget decomposition. One global stall freezes every stage while the
// output beat waits for out_ready.
// Optional feature macro: CT_MULT_DECOMP_EN enables the base-2^LOG_BASE
// decomposition of d2 onto d2_digits. When it is undefined, d2_digits is
// tied to zero.
module ct_ct_mult_pipe #(
  parameter int          W          = 32,
  parameter logic [W-1:0] Q         = 32'hFFF00001,
  parameter int          N          = 1024,
  parameter int          LANES      = 4,
  parameter int          LOG_BASE   = 8,
  parameter int          NUM_DIGITS = 4,
  localparam int         NB         = N / LANES,
  localparam int         IW         = (NB > 1) ? $clog2(NB) : 1,
  localparam int         DW         = NUM_DIGITS * LOG_BASE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LANES*W-1:0]    a1,
  input  logic [LANES*W-1:0]    b1,
  input  logic [LANES*W-1:0]    a2,
  input  logic [LANES*W-1:0]    b2,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [LANES*W-1:0]    d0,
  output logic [LANES*W-1:0]    d1,
  output logic [LANES*W-1:0]    d2,
  output logic [LANES*DW-1:0]   d2_digits,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IW-1:0]         out_idx,
  output logic                  out_last,
  output logic                  done,
  output logic                  busy
);

  localparam logic [2*W-1:0] Q_2W     = {{W{1'b0}}, Q};
  localparam logic [W:0]     Q_W1     = {1'b0, Q};
  localparam logic [IW-1:0]  LAST_IDX = IW'(NB - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  logic stall;
  logic accept;
  logic deliver;

  // S1: raw products
  logic                          v1_q, v1_d;
  logic [IW-1:0]                 idx1_q, idx1_d;
  logic [LANES-1:0][2*W-1:0]     p_bb_q, p_bb_d;
  logic [LANES-1:0][2*W-1:0]     p_aa_q, p_aa_d;
  logic [LANES-1:0][2*W-1:0]     p_ab_q, p_ab_d;
  logic [LANES-1:0][2*W-1:0]     p_ba_q, p_ba_d;

  // S2: reduced d0/d1 and the unreduced W+1 bit D2 sum
  logic                          v2_q, v2_d;
  logic [IW-1:0]                 idx2_q, idx2_d;
  logic [LANES-1:0][W-1:0]       r0_q, r0_d;
  logic [LANES-1:0][W-1:0]       r1_q, r1_d;
  logic [LANES-1:0][W:0]         s2_q, s2_d;

  // S3: output registers
  logic                          v3_q, v3_d;
  logic [IW-1:0]                 idx3_q, idx3_d;
  logic                          last_q, last_d;
  logic [LANES-1:0][W-1:0]       d0_q, d0_d;
  logic [LANES-1:0][W-1:0]       d1_q, d1_d;
  logic [LANES-1:0][W-1:0]       d2_q, d2_d;

  // A held output beat freezes the whole pipe; a bubble at S3 never stalls.
  assign stall   = v3_q && !out_ready;
  assign accept  = in_valid && in_ready;
  assign deliver = v3_q && out_ready;

  // FSM state register plus input beat counter and done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // FSM next state, beat counter wrap and done generation
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          // With a single beat per ciphertext the first beat is also the last.
          state_d = (cnt_q == LAST_IDX) ? DRAIN : ACCEPT;
        end else begin
          state_d = IDLE;
        end
      end
      ACCEPT: begin
        if (accept && (cnt_q == LAST_IDX)) begin
          state_d = DRAIN;
        end else begin
          state_d = ACCEPT;
        end
      end
      DRAIN: begin
        if (deliver && last_q) begin
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      cnt_d = (cnt_q == LAST_IDX) ? '0 : cnt_q + IW'(1);
    end else begin
      cnt_d = cnt_q;
    end

    done_d = deliver && last_q;
  end

  // FSM outputs: input handshake and busy flag
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = !stall;
        busy     = 1'b0;
      end
      ACCEPT: begin
        in_ready = !stall;
        busy     = 1'b1;
      end
      DRAIN: begin
        in_ready = 1'b0;
        busy     = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
        busy     = 1'b0;
      end
    endcase
  end

  // Datapath next values for all three stages (loaded only when not stalled)
  always_comb begin
    v1_d   = accept;
    idx1_d = cnt_q;
    v2_d   = v1_q;
    idx2_d = idx1_q;
    v3_d   = v2_q;
    idx3_d = idx2_q;
    last_d = (idx2_q == LAST_IDX);
    for (int l = 0; l < LANES; l++) begin
      p_bb_d[l] = (2*W)'(b1[l*W +: W]) * (2*W)'(b2[l*W +: W]);
      p_aa_d[l] = (2*W)'(a1[l*W +: W]) * (2*W)'(a2[l*W +: W]);
      p_ab_d[l] = (2*W)'(a1[l*W +: W]) * (2*W)'(b2[l*W +: W]);
      p_ba_d[l] = (2*W)'(b1[l*W +: W]) * (2*W)'(a2[l*W +: W]);
      r0_d[l]   = W'(p_bb_q[l] % Q_2W);
      r1_d[l]   = W'(p_aa_q[l] % Q_2W);
      // Both cross terms are below Q, so the sum is below 2Q and fits W+1 bits.
      s2_d[l]   = (W+1)'(W'(p_ab_q[l] % Q_2W)) + (W+1)'(W'(p_ba_q[l] % Q_2W));
      d0_d[l]   = r0_q[l];
      d1_d[l]   = r1_q[l];
      d2_d[l]   = (s2_q[l] >= Q_W1) ? W'(s2_q[l] - Q_W1) : W'(s2_q[l]);
    end
  end

  // Pipeline registers; every stage holds during a stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q   <= 1'b0;
      idx1_q <= '0;
      p_bb_q <= '0;
      p_aa_q <= '0;
      p_ab_q <= '0;
      p_ba_q <= '0;
      v2_q   <= 1'b0;
      idx2_q <= '0;
      r0_q   <= '0;
      r1_q   <= '0;
      s2_q   <= '0;
      v3_q   <= 1'b0;
      idx3_q <= '0;
      last_q <= 1'b0;
      d0_q   <= '0;
      d1_q   <= '0;
      d2_q   <= '0;
    end else if (!stall) begin
      v1_q   <= v1_d;
      idx1_q <= idx1_d;
      p_bb_q <= p_bb_d;
      p_aa_q <= p_aa_d;
      p_ab_q <= p_ab_d;
      p_ba_q <= p_ba_d;
      v2_q   <= v2_d;
      idx2_q <= idx2_d;
      r0_q   <= r0_d;
      r1_q   <= r1_d;
      s2_q   <= s2_d;
      v3_q   <= v3_d;
      idx3_q <= idx3_d;
      last_q <= last_d;
      d0_q   <= d0_d;
      d1_q   <= d1_d;
      d2_q   <= d2_d;
    end
  end

`ifdef CT_MULT_DECOMP_EN
  logic [LANES-1:0][DW-1:0] dig_q, dig_d;

  // Digit i of each lane is bits [i*LOG_BASE +: LOG_BASE] of the reduced d2
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        dig_d[l][i*LOG_BASE +: LOG_BASE] = LOG_BASE'(DW'(d2_d[l]) >> (i*LOG_BASE));
      end
    end
  end

  // Digit register sits in S3 alongside d2 and stalls with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig_q <= '0;
    end else if (!stall) begin
      dig_q <= dig_d;
    end
  end

  assign d2_digits = dig_q;
`else
  assign d2_digits = '0;
`endif

  assign d0        = d0_q;
  assign d1        = d1_q;
  assign d2        = d2_q;
  assign out_valid = v3_q;
  assign out_idx   = idx3_q;
  assign out_last  = last_q;
  assign done      = done_q;

endmodule
